// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        D_WAIT = 2'b01,
        I_WAIT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// EX operand bypass select for one source operand; MEM result beats WB, x0 is never bypassed.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
    input  logic                      reg_write_m_i,
    input  logic                      reg_write_w_i,
    output fwd_sel_t                  fwd_sel_o
);

    always_comb begin
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            fwd_sel_o = FWD_WB;
        end else begin
            fwd_sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage cached core.
// Optional perf counters (stall_cycles, flush_count) are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      RegWrite_e,
    input  logic                      RegWrite_m,
    input  logic                      RegWrite_w,
    input  logic [1:0]                ResultSrc_e,
    input  logic                      PCSrc_e,
    input  logic                      icache_miss_f,
    input  logic                      icache_ready,
    input  logic                      dcache_miss_m,
    input  logic                      dcache_ready,
    output logic                      en_pc,
    output logic                      en_fd,
    output logic                      en_de,
    output logic                      en_em,
    output logic                      en_mw,
    output logic                      flush_fd_n,
    output logic                      flush_de_n,
    output logic                      valid_m,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_count
`endif
);

    state_t   state_q, state_d;
    logic     redirect_pend_q, redirect_pend_d;
    logic     load_use;
    logic     redirect_c;
    logic     en_pc_c, en_fd_c, en_de_c, en_em_c, en_mw_c;
    logic     flush_fd_n_c, flush_de_n_c, valid_m_c;
    fwd_sel_t fwd_a, fwd_b;

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs_e_i        (rs1_e),
        .rd_m_i        (rd_m),
        .rd_w_i        (rd_w),
        .reg_write_m_i (RegWrite_m),
        .reg_write_w_i (RegWrite_w),
        .fwd_sel_o     (fwd_a)
    );

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs_e_i        (rs2_e),
        .rd_m_i        (rd_m),
        .rd_w_i        (rd_w),
        .reg_write_m_i (RegWrite_m),
        .reg_write_w_i (RegWrite_w),
        .fwd_sel_o     (fwd_b)
    );

    assign load_use = (ResultSrc_e == RESULT_SRC_LOAD) && RegWrite_e && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        redirect_c      = 1'b0;
        en_pc_c         = 1'b1;
        en_fd_c         = 1'b1;
        en_de_c         = 1'b1;
        en_em_c         = 1'b1;
        en_mw_c         = 1'b1;
        flush_fd_n_c    = 1'b1;
        flush_de_n_c    = 1'b1;
        valid_m_c       = 1'b1;

        unique case (state_q)
            RUN: begin
                if (dcache_miss_m) begin
                    {en_pc_c, en_fd_c, en_de_c, en_em_c, en_mw_c} = '0;
                    valid_m_c = 1'b0;
                    state_d   = D_WAIT;
                end else begin
                    if (PCSrc_e) begin
                        flush_fd_n_c = 1'b0;
                        flush_de_n_c = 1'b0;
                        redirect_c   = 1'b1;
                    end else if (load_use) begin
                        en_pc_c      = 1'b0;
                        en_fd_c      = 1'b0;
                        flush_de_n_c = 1'b0;
                    end
                    if (icache_miss_f) begin
                        state_d = I_WAIT;
                        // A held load-use consumer in ID must not be bubbled away.
                        if (!load_use) flush_fd_n_c = 1'b0;
                        if (PCSrc_e) redirect_pend_d = 1'b1;
                        else         en_pc_c         = 1'b0;
                    end
                end
            end

            D_WAIT: begin
                if (dcache_ready) begin
                    state_d = RUN;
                    if (PCSrc_e) begin
                        flush_fd_n_c = 1'b0;
                        flush_de_n_c = 1'b0;
                        redirect_c   = 1'b1;
                    end else if (load_use) begin
                        en_pc_c      = 1'b0;
                        en_fd_c      = 1'b0;
                        flush_de_n_c = 1'b0;
                    end
                end else begin
                    {en_pc_c, en_fd_c, en_de_c, en_em_c, en_mw_c} = '0;
                    valid_m_c = 1'b0;
                end
            end

            I_WAIT: begin
                en_pc_c      = 1'b0;
                flush_fd_n_c = 1'b0;
                if (dcache_miss_m) begin
                    // Back end frozen in place; the fetch may still complete into IF/ID.
                    {en_de_c, en_em_c, en_mw_c} = '0;
                    valid_m_c = 1'b0;
                    if (icache_ready) begin
                        state_d         = D_WAIT;
                        redirect_pend_d = 1'b0;
                        if (!redirect_pend_q) begin
                            en_pc_c      = 1'b1;
                            flush_fd_n_c = 1'b1;
                        end
                    end
                end else begin
                    if (PCSrc_e) begin
                        en_pc_c         = 1'b1;
                        flush_de_n_c    = 1'b0;
                        redirect_pend_d = 1'b1;
                        redirect_c      = 1'b1;
                    end else if (load_use) begin
                        en_fd_c      = 1'b0;
                        flush_fd_n_c = 1'b1;
                        flush_de_n_c = 1'b0;
                    end
                    if (icache_ready) begin
                        state_d         = RUN;
                        redirect_pend_d = 1'b0;
                        if (redirect_pend_q || PCSrc_e) begin
                            en_fd_c      = 1'b1;
                            flush_fd_n_c = 1'b0;
                        end else if (!load_use) begin
                            // PC steps past the instruction now captured into IF/ID.
                            en_pc_c      = 1'b1;
                            en_fd_c      = 1'b1;
                            flush_fd_n_c = 1'b1;
                        end
                    end
                end
            end

            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q         <= RUN;
            redirect_pend_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
        end
    end

    // Reset forces every control low without waiting for a clock edge.
    assign en_pc       = rst_n & en_pc_c;
    assign en_fd       = rst_n & en_fd_c;
    assign en_de       = rst_n & en_de_c;
    assign en_em       = rst_n & en_em_c;
    assign en_mw       = rst_n & en_mw_c;
    assign flush_fd_n  = rst_n & flush_fd_n_c;
    assign flush_de_n  = rst_n & flush_de_n_c;
    assign valid_m     = rst_n & valid_m_c;
    assign forward_a_e = rst_n ? 2'(fwd_a) : 2'(FWD_RF);
    assign forward_b_e = rst_n ? 2'(fwd_b) : 2'(FWD_RF);

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!en_pc_c && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 1'b1;
            if (redirect_c && (flush_count_q != '1)) flush_count_q <= flush_count_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    logic unused_cnt_width;
    assign unused_cnt_width = (CNT_WIDTH == 0);
`endif

endmodule
